// File: rtl/uart_core_param.sv
// uart_core_param: UART TX/RX engine with TX/RX FIFOs, runtime frame format and baud divisor.
module uart_core_param #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                cfg_div_i,
  input  logic [$clog2(DATA_W+1)-1:0]     cfg_bits_i,
  input  logic                            cfg_par_en_i,
  input  logic                            cfg_par_odd_i,
  input  logic                            cfg_stop2_i,
  input  logic [$clog2(FIFO_DEPTH):0]     cfg_rx_thr_i,
  input  logic [2:0]                      cfg_ie_i,
  input  logic [DATA_W-1:0]               tx_data_i,
  input  logic                            tx_valid_i,
  output logic                            tx_ready_o,
  output logic [DATA_W+1:0]               rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  input  logic                            err_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]     tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0]     rx_level_o,
  output logic                            tx_busy_o,
  output logic [2:0]                      err_o,
  output logic                            irq_o,
  input  logic                            rx_i,
  output logic                            tx_o
);
  localparam int BW = $clog2(DATA_W+1);
  localparam int LW = $clog2(FIFO_DEPTH)+1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4, S_LOAD = 3'd5;
  logic [DIV_W-1:0]       r_div_cnt, w_div_max;
  logic                   w_tick;
  logic [BW-1:0]          w_bits;
  logic [DATA_W-1:0]      w_mask;
  logic [DATA_W-1:0]      r_txm [FIFO_DEPTH];
  logic [DATA_W+1:0]      r_rxm [FIFO_DEPTH];
  logic [AW-1:0]          r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [LW-1:0]          r_tx_lvl, r_rx_lvl;
  logic                   w_txf_empty, w_txf_full, w_rxf_empty, w_rxf_full, w_tx_wr, w_rx_wr, w_rx_rd;
  logic [2:0]             r_tx_st, r_rx_st;
  logic [OW-1:0]          r_tx_os, r_rx_os;
  logic [BW-1:0]          r_tx_bit, r_tx_bits, r_rx_bit, r_rx_bits;
  logic [DATA_W-1:0]      r_tx_sh, r_rx_sh, w_txf_data;
  logic                   r_tx_par, r_tx_pen, r_tx_stop2, w_tx_os_last, w_tx_end, w_tx_pop;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx, r_rx_prev, w_fall, r_rx_pen, r_rx_pacc, r_rx_perr, w_rx_os_last, w_rx_push;
  logic [DATA_W+1:0]      w_rx_word;
  logic [2:0]             r_err, w_err_set;
  logic                   r_irq;
  assign w_div_max    = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
  assign w_tick       = r_div_cnt >= w_div_max - DIV_W'(1);
  assign w_bits       = (cfg_bits_i < BW'(5)) ? BW'(5) : (cfg_bits_i > BW'(DATA_W)) ? BW'(DATA_W) : cfg_bits_i;
  assign w_mask       = ~({DATA_W{1'b1}} << w_bits);
  assign w_txf_empty  = r_tx_lvl == '0;
  assign w_txf_full   = r_tx_lvl == LW'(FIFO_DEPTH);
  assign w_rxf_empty  = r_rx_lvl == '0;
  assign w_rxf_full   = r_rx_lvl == LW'(FIFO_DEPTH);
  assign w_tx_wr      = tx_valid_i && !w_txf_full;
  assign w_rx_rd      = rx_ready_i && !w_rxf_empty;
  assign w_rx_wr      = w_rx_push && (!w_rxf_full || w_rx_rd);
  assign w_txf_data   = r_txm[r_tx_rp];
  assign tx_ready_o   = !w_txf_full;
  assign rx_valid_o   = !w_rxf_empty;
  assign rx_data_o    = r_rxm[r_rx_rp];
  assign tx_level_o   = r_tx_lvl;
  assign rx_level_o   = r_rx_lvl;
  assign tx_busy_o    = r_tx_st != S_IDLE;
  assign err_o        = r_err;
  assign irq_o        = r_irq;
  assign w_tx_os_last = r_tx_os == OW'(OVERSAMPLE-1);
  assign w_tx_end     = r_tx_st == S_STOP && w_tick && w_tx_os_last && r_tx_bit == BW'(r_tx_stop2);
  assign w_tx_pop     = (r_tx_st == S_IDLE || w_tx_end) && !w_txf_empty;
  assign tx_o         = (r_tx_st == S_START) ? 1'b0 : (r_tx_st == S_DATA) ? r_tx_sh[0] : (r_tx_st == S_PAR) ? r_tx_par : 1'b1;
  assign w_rx         = r_sync[SYNC_STAGES-1];
  assign w_fall       = r_rx_prev && !w_rx;
  assign w_rx_os_last = r_rx_os == OW'(OVERSAMPLE-1);
  assign w_rx_push    = r_rx_st == S_STOP && w_tick && w_rx_os_last;
  assign w_rx_word    = {!w_rx, r_rx_perr, r_rx_sh >> (BW'(DATA_W) - r_rx_bits)};
  assign w_err_set    = {w_rx_push && w_rxf_full && !w_rx_rd, w_rx_push && !w_rx, w_rx_push && r_rx_perr};
  always_ff @(posedge clk) begin
    if (w_tx_wr) r_txm[r_tx_wp] <= tx_data_i;
    if (w_rx_wr) r_rxm[r_rx_wp] <= w_rx_word;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div_cnt <= '0;
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_lvl <= '0;
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_lvl <= '0;
      r_err <= '0; r_irq <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_tx_wp <= r_tx_wp + AW'(w_tx_wr);
      r_tx_rp <= r_tx_rp + AW'(w_tx_pop);
      r_tx_lvl <= r_tx_lvl + LW'(w_tx_wr) - LW'(w_tx_pop);
      r_rx_wp <= r_rx_wp + AW'(w_rx_wr);
      r_rx_rp <= r_rx_rp + AW'(w_rx_rd);
      r_rx_lvl <= r_rx_lvl + LW'(w_rx_wr) - LW'(w_rx_rd);
      r_err <= (err_clr_i ? 3'b000 : r_err) | w_err_set;
      r_irq <= (cfg_ie_i[0] && rx_level_o >= cfg_rx_thr_i && cfg_rx_thr_i != '0) ||
               (cfg_ie_i[1] && tx_level_o == '0 && !tx_busy_o) || (cfg_ie_i[2] && |r_err);
    end
  // A pop at the end of STOP chains straight into START so back-to-back frames have no gap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_st <= S_IDLE; r_tx_os <= '0; r_tx_bit <= '0; r_tx_bits <= '0;
      r_tx_sh <= '0; r_tx_par <= 1'b0; r_tx_pen <= 1'b0; r_tx_stop2 <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_sh <= w_txf_data;
      r_tx_par <= ^(w_txf_data & w_mask) ^ cfg_par_odd_i;
      r_tx_bits <= w_bits; r_tx_pen <= cfg_par_en_i; r_tx_stop2 <= cfg_stop2_i;
      r_tx_os <= '0; r_tx_bit <= '0;
      r_tx_st <= (r_tx_st == S_IDLE) ? S_LOAD : S_START;
    end else if (r_tx_st == S_LOAD) begin
      if (w_tick) r_tx_st <= S_START;
    end else if (r_tx_st != S_IDLE && w_tick) begin
      r_tx_os <= r_tx_os + OW'(1);
      if (w_tx_os_last) begin
        r_tx_os <= '0;
        r_tx_bit <= '0;
        if (r_tx_st == S_START) r_tx_st <= S_DATA;
        else if (r_tx_st == S_DATA) begin
          r_tx_sh <= r_tx_sh >> 1;
          if (r_tx_bit == r_tx_bits - BW'(1)) r_tx_st <= r_tx_pen ? S_PAR : S_STOP;
          else r_tx_bit <= r_tx_bit + BW'(1);
        end else if (r_tx_st == S_PAR) r_tx_st <= S_STOP;
        else if (r_tx_bit == BW'(r_tx_stop2)) r_tx_st <= S_IDLE;
        else r_tx_bit <= r_tx_bit + BW'(1);
      end
    end
  // The frame is pushed at the first stop-bit sample; any second stop bit is just idle line to RX.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '1; r_rx_prev <= 1'b1;
      r_rx_st <= S_IDLE; r_rx_os <= '0; r_rx_bit <= '0; r_rx_bits <= '0;
      r_rx_sh <= '0; r_rx_pen <= 1'b0; r_rx_pacc <= 1'b0; r_rx_perr <= 1'b0;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, rx_i});
      r_rx_prev <= w_rx;
      if (r_rx_st == S_IDLE) begin
        if (w_fall) begin
          r_rx_st <= S_START; r_rx_os <= '0; r_rx_bit <= '0; r_rx_sh <= '0;
          r_rx_bits <= w_bits; r_rx_pen <= cfg_par_en_i; r_rx_pacc <= cfg_par_odd_i; r_rx_perr <= 1'b0;
        end
      end else if (w_tick) begin
        r_rx_os <= r_rx_os + OW'(1);
        if (r_rx_st == S_START) begin
          if (r_rx_os == OW'(OVERSAMPLE/2-1)) begin
            r_rx_os <= '0;
            r_rx_st <= w_rx ? S_IDLE : S_DATA;
          end
        end else if (w_rx_os_last) begin
          r_rx_os <= '0;
          if (r_rx_st == S_DATA) begin
            r_rx_sh <= {w_rx, r_rx_sh[DATA_W-1:1]};
            r_rx_pacc <= r_rx_pacc ^ w_rx;
            r_rx_bit <= r_rx_bit + BW'(1);
            if (r_rx_bit == r_rx_bits - BW'(1)) r_rx_st <= r_rx_pen ? S_PAR : S_STOP;
          end else if (r_rx_st == S_PAR) begin
            r_rx_perr <= w_rx != r_rx_pacc;
            r_rx_st <= S_STOP;
          end else r_rx_st <= S_IDLE;
        end
      end
    end
endmodule
